pattern_merge_scheduler: RTL and testbench
==========================================

// Module: pattern_merge_scheduler
// PURPOSE
//  Round-robin scheduler that shares one merged-pattern datapath (flat gate/DFF netlist, IN_W inputs, OUT_W outputs)
//  between NUM_REQ requesters. Accepts one request at a time, drives its vector onto the datapath, waits LATENCY
//  clocks for the registered outputs to settle, captures them and returns them tagged with the requester id.
//  Sits between the stimulus/requester layer and the generated netlist instance.
// PARAMETERS
//  NUM_REQ  4   number of requesters (2..16)
//  IN_W     11  datapath input vector width
//  OUT_W    9   datapath output vector width
//  LATENCY  3   clocks dp_in is held before dp_out is sampled (1..15)
//  ID_W     2   requester id width, = clog2(NUM_REQ)
// PORTS
//  blif_clk_net    in   1             clock; all state updates on rising edge
//  blif_reset_net  in   1             synchronous reset, active-high
//  req_valid       in   NUM_REQ       per-requester request pending
//  req_data        in   NUM_REQ*IN_W  per-requester input vectors; requester i at [i*IN_W +: IN_W]
//  req_ready       out  NUM_REQ       one-hot accept pulse; request i taken when req_valid[i] & req_ready[i]
//  dp_in           out  IN_W          vector driven to the shared datapath
//  dp_clr          out  1             datapath clear request (active-high), pulses after reset
//  dp_out          in   OUT_W         datapath outputs
//  rsp_valid       out  1             response available
//  rsp_ready       in   1             response consumer ready
//  rsp_id          out  ID_W          requester id of response
//  rsp_data        out  OUT_W         captured dp_out
//  busy            out  1             high in any state other than IDLE
// BEHAVIOUR
//  - Reset: state=CLR, rr_ptr=0, req_ready=0, dp_in=0, rsp_valid=0, rsp_id=0, rsp_data=0, hold_cnt=0; dp_clr=1 while
//    blif_reset_net=1 and for exactly one cycle after release (CLR state), then IDLE.
//  - States: CLR -> IDLE -> RUN -> RESP -> IDLE.
//  - IDLE: if any req_valid, grant g = first i with req_valid[i] scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ;
//    req_ready[g]=1 combinationally that cycle only; latch req_data[g] into dp_in and g into rsp_id at clock edge;
//    hold_cnt=LATENCY-1; go RUN. No req_valid -> stay IDLE; dp_in holds 0 in IDLE.
//  - RUN: dp_in stable; decrement hold_cnt each cycle; when hold_cnt==0, rsp_data<=dp_out, rsp_valid<=1, go RESP.
//    So request accepted at edge T -> dp_in valid from T+1 -> rsp_valid high from T+LATENCY+1.
//  - RESP: rsp_valid/rsp_id/rsp_data stable until rsp_valid&rsp_ready; on that edge rsp_valid<=0, dp_in<=0,
//    rr_ptr<=(rsp_id+1) mod NUM_REQ, go IDLE. Next grant no earlier than the following cycle (one request in flight).
//  - req_ready is 0 in CLR, RUN and RESP. Requesters deasserting req_valid before grant are simply skipped.
//  - Reset asserted mid-operation: transaction abandoned, no response issued, all outputs to reset values.
//  - rr_ptr wraps NUM_REQ-1 -> 0; requester ids >= NUM_REQ never granted.
// CONFIGURATION
//  PMS_STATS_EN defined: adds inputs stats_sel [ID_W] and stats_clr [1], output stats_cnt [16]; one 16-bit counter per
//    requester increments on each completed response handshake for that id, saturates at 16'hFFFF, cleared by reset or
//    stats_clr (clear wins over same-cycle increment); stats_cnt = counter[stats_sel] combinationally.
//  PMS_STATS_EN undefined: ports and counters absent; scheduling behaviour identical.
// TESTING
//  - Reset: hold blif_reset_net 3 cycles, release -> dp_clr=1 for 1 cycle, all other outputs 0, busy=0 after CLR.
//  - Single request: req_valid=4'b0100, data 11'h5A3, LATENCY=3 -> req_ready=4'b0100 one cycle, dp_in=11'h5A3
//    next cycle, rsp_valid 4 cycles after accept, rsp_id=2, rsp_data = dp_out at sample cycle.
//  - Fairness: all 4 req_valid held, rsp_ready=1 -> grant order 0,1,2,3,0,1 ... each id once per 4 responses.
//  - Backpressure: rsp_ready=0 for 10 cycles in RESP -> rsp_* stable, req_ready=0 throughout, grant resumes after handshake.
//  - Mid-op reset: assert reset in RUN -> next cycle rsp_valid=0, dp_in=0, rr_ptr=0; no response for that request.
//  - PMS_STATS_EN: 70000 responses to id 1 -> stats_cnt(sel=1)=16'hFFFF; stats_clr with completing handshake -> 0.

Source files
------------

// File: rtl/pattern_merge_scheduler.sv
// Round-robin scheduler sharing one merged-pattern datapath between NUM_REQ requesters, one request in flight.
// Optional feature: define PMS_STATS_EN for per-requester saturating response counters (stats_sel/stats_clr/stats_cnt).
module pattern_merge_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int IN_W    = 11,
    parameter int OUT_W   = 9,
    parameter int LATENCY = 3,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                    blif_clk_net,
    input  logic                    blif_reset_net,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ*IN_W-1:0] req_data,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic [IN_W-1:0]         dp_in,
    output logic                    dp_clr,
    input  logic [OUT_W-1:0]        dp_out,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [ID_W-1:0]         rsp_id,
    output logic [OUT_W-1:0]        rsp_data,
    output logic                    busy
`ifdef PMS_STATS_EN
    ,
    input  logic [ID_W-1:0]         stats_sel,
    input  logic                    stats_clr,
    output logic [15:0]             stats_cnt
`endif
);

    localparam logic [1:0] ST_CLR  = 2'd0;
    localparam logic [1:0] ST_IDLE = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [IN_W-1:0]  dp_in_q, dp_in_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]  rsp_id_q, rsp_id_d;
    logic [OUT_W-1:0] rsp_data_q, rsp_data_d;
    logic [3:0]       hold_cnt_q, hold_cnt_d;

    logic             grant_found;
    logic [ID_W-1:0]  grant_id;
    logic [ID_W-1:0]  cand;
    int               scan;
    logic [IN_W-1:0]  grant_data;

    // Scan downwards from the farthest offset so the requester closest to rr_ptr wins last.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        cand        = '0;
        scan        = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            scan = int'(rr_ptr_q) + k;
            if (scan >= NUM_REQ) scan = scan - NUM_REQ;
            cand = ID_W'(scan);
            if (req_valid[cand]) begin
                grant_found = 1'b1;
                grant_id    = cand;
            end
        end
    end

    always_comb begin
        grant_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id == ID_W'(i)) grant_data = req_data[i*IN_W +: IN_W];
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        dp_in_d     = dp_in_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        hold_cnt_d  = hold_cnt_q;
        case (state_q)
            ST_CLR: state_d = ST_IDLE;
            ST_IDLE: begin
                if (grant_found) begin
                    dp_in_d    = grant_data;
                    rsp_id_d   = grant_id;
                    hold_cnt_d = 4'(LATENCY - 1);
                    state_d    = ST_RUN;
                end
            end
            ST_RUN: begin
                if (hold_cnt_q == 4'd0) begin
                    rsp_data_d  = dp_out;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end else begin
                    hold_cnt_d = hold_cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    dp_in_d     = '0;
                    rr_ptr_d    = (rsp_id_q == ID_W'(NUM_REQ - 1)) ? '0 : rsp_id_q + 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_CLR;
        endcase
    end

    always_ff @(posedge blif_clk_net) begin
        if (blif_reset_net) begin
            state_q     <= ST_CLR;
            rr_ptr_q    <= '0;
            dp_in_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
            hold_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            dp_in_q     <= dp_in_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
            hold_cnt_q  <= hold_cnt_d;
        end
    end

    // Gate the accept pulse with reset so a requester is never told it was taken while reset is held.
    assign req_ready = (state_q == ST_IDLE && !blif_reset_net && grant_found)
                       ? (NUM_REQ'(1) << grant_id) : '0;
    assign dp_clr    = blif_reset_net | (state_q == ST_CLR);
    assign dp_in     = dp_in_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = (state_q != ST_IDLE);

`ifdef PMS_STATS_EN
    logic [15:0] stats_q [NUM_REQ];

    // Clear has priority over a completing handshake in the same cycle.
    always_ff @(posedge blif_clk_net) begin
        if (blif_reset_net || stats_clr) begin
            for (int i = 0; i < NUM_REQ; i++) stats_q[i] <= '0;
        end else if (rsp_valid_q && rsp_ready && stats_q[rsp_id_q] != 16'hFFFF) begin
            stats_q[rsp_id_q] <= stats_q[rsp_id_q] + 16'd1;
        end
    end

    assign stats_cnt = (int'(stats_sel) < NUM_REQ) ? stats_q[stats_sel] : 16'h0;
`endif

endmodule

// File: tb/tb_pattern_merge_scheduler.sv
// Self-checking bench for pattern_merge_scheduler: vector table of requests, scoreboard of expected responses.
module tb_pattern_merge_scheduler;

    localparam int NUM_REQ = 4;
    localparam int IN_W    = 11;
    localparam int OUT_W   = 9;
    localparam int LATENCY = 3;
    localparam int ID_W    = 2;
    localparam int NVEC    = 12;

    logic                    clk = 1'b0;
    logic                    reset;
    logic [NUM_REQ-1:0]      req_valid;
    logic [NUM_REQ*IN_W-1:0] req_data;
    logic [NUM_REQ-1:0]      req_ready;
    logic [IN_W-1:0]         dp_in;
    logic                    dp_clr;
    logic [OUT_W-1:0]        dp_out;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [ID_W-1:0]         rsp_id;
    logic [OUT_W-1:0]        rsp_data;
    logic                    busy;

    pattern_merge_scheduler #(
        .NUM_REQ(NUM_REQ), .IN_W(IN_W), .OUT_W(OUT_W), .LATENCY(LATENCY), .ID_W(ID_W)
    ) dut (
        .blif_clk_net(clk),
        .blif_reset_net(reset),
        .req_valid(req_valid),
        .req_data(req_data),
        .req_ready(req_ready),
        .dp_in(dp_in),
        .dp_clr(dp_clr),
        .dp_out(dp_out),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_id(rsp_id),
        .rsp_data(rsp_data),
        .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [OUT_W-1:0] dpf(input logic [IN_W-1:0] x);
        return x[8:0] ^ {x[10:9], x[10:9], x[10:9], x[10:9], 1'b1} ^ 9'h0A5;
    endfunction

    // Datapath stand-in: two register stages, so its output is settled only after dp_in has been held a while.
    logic [OUT_W-1:0] s1, s2;
    always @(posedge clk) begin
        s1 <= dpf(dp_in);
        s2 <= s1;
    end
    assign dp_out = s2;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [NUM_REQ-1:0]      valid;
        logic [NUM_REQ*IN_W-1:0] data;
        int                      stall;
        int                      expId;
    } vec_t;

    typedef struct {
        logic [ID_W-1:0]  id;
        logic [OUT_W-1:0] data;
        int               acceptCyc;
    } exp_t;

    vec_t vecs[NVEC];
    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        int w = 0;
        logic [IN_W-1:0] d;
        req_valid = v.valid;
        req_data  = v.data;
        d = v.data[v.expId*IN_W +: IN_W];
        #1;
        while (req_ready == '0 && w < 20) begin
            @(negedge clk); #1;
            w++;
        end
        if (w >= 20) begin
            checks++; errors++;
            $display("[TB] FAIL grant_timeout: got no req_ready expected id %0d", v.expId);
        end else begin
            chk("grant_latency", 64'(w), 64'd0);
            chk("req_ready", 64'(req_ready), 64'(1) << v.expId);
            sbq.push_back('{id: ID_W'(v.expId), data: dpf(d), acceptCyc: cyc});
            @(negedge clk); #1;
            chk("dp_in_latched", 64'(dp_in), 64'(d));
            chk("busy_run", 64'(busy), 64'd1);
            chk("req_ready_run", 64'(req_ready), 64'd0);
        end
    endtask

    task automatic checkOutput(input vec_t v);
        int w = 0;
        exp_t e;
        logic [IN_W-1:0] d;
        d = v.data[v.expId*IN_W +: IN_W];
        while (!rsp_valid && w < 20) begin
            chk("dp_in_hold", 64'(dp_in), 64'(d));
            @(negedge clk); #1;
            w++;
        end
        if (w >= 20 || sbq.size() == 0) begin
            checks++; errors++;
            $display("[TB] FAIL rsp_timeout: got rsp_valid=%0b expected 1", rsp_valid);
        end else begin
            e = sbq.pop_front();
            chk("rsp_latency", 64'(cyc - e.acceptCyc), 64'(LATENCY + 1));
            chk("rsp_id", 64'(rsp_id), 64'(e.id));
            chk("rsp_data", 64'(rsp_data), 64'(e.data));
            for (int s = 0; s < v.stall; s++) begin
                @(negedge clk); #1;
                chk("stall_valid", 64'(rsp_valid), 64'd1);
                chk("stall_id", 64'(rsp_id), 64'(e.id));
                chk("stall_data", 64'(rsp_data), 64'(e.data));
                chk("stall_req_ready", 64'(req_ready), 64'd0);
            end
            rsp_ready = 1'b1;
            @(negedge clk); #1;
            rsp_ready = 1'b0;
            chk("post_hs_valid", 64'(rsp_valid), 64'd0);
            chk("post_hs_dp_in", 64'(dp_in), 64'd0);
            chk("post_hs_busy", 64'(busy), 64'd0);
        end
    endtask

    initial begin
        logic [3:0] vl [NVEC] = '{4'b0100, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF,
                                  4'b0001, 4'b1010, 4'b1010, 4'b0110, 4'b0011};
        int ex [NVEC] = '{2, 3, 0, 1, 2, 3, 0, 0, 1, 3, 1, 0};
        vec_t mv;

        for (int i = 0; i < NVEC; i++) begin
            vecs[i].valid = vl[i];
            vecs[i].data  = {12'($urandom), $urandom};
            vecs[i].stall = (i == 1) ? 10 : (i % 3);
            vecs[i].expId = ex[i];
        end
        vecs[0].data[2*IN_W +: IN_W] = 11'h5A3;

        // Reset held with every requester asking: nothing may be accepted.
        reset     = 1'b1;
        req_valid = 4'hF;
        req_data  = {12'($urandom), $urandom};
        rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_dp_clr", 64'(dp_clr), 64'd1);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_dp_in", 64'(dp_in), 64'd0);
        chk("rst_rsp_id", 64'(rsp_id), 64'd0);
        chk("rst_rsp_data", 64'(rsp_data), 64'd0);
        reset = 1'b0;
        #1;
        chk("clr_dp_clr", 64'(dp_clr), 64'd1);
        chk("clr_req_ready", 64'(req_ready), 64'd0);
        req_valid = '0;
        @(negedge clk); #1;
        chk("idle_dp_clr", 64'(dp_clr), 64'd0);
        chk("idle_busy", 64'(busy), 64'd0);
        chk("idle_req_ready", 64'(req_ready), 64'd0);
        @(negedge clk); #1;
        chk("idle_dp_in", 64'(dp_in), 64'd0);
        chk("idle_rsp_valid", 64'(rsp_valid), 64'd0);

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i]);
            checkOutput(vecs[i]);
        end
        req_valid = '0;

        // Reset while a request is in RUN: it must vanish without a response and rr_ptr restarts at 0.
        @(negedge clk); #1;
        req_valid = 4'b0100;
        req_data  = {12'($urandom), $urandom};
        #1;
        chk("midrst_grant", 64'(req_ready), 64'b0100);
        @(negedge clk); #1;
        req_valid = '0;
        chk("midrst_busy", 64'(busy), 64'd1);
        reset = 1'b1;
        #1;
        chk("midrst_dp_clr", 64'(dp_clr), 64'd1);
        @(negedge clk); #1;
        chk("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("midrst_dp_in", 64'(dp_in), 64'd0);
        reset     = 1'b0;
        rsp_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk); #1;
            chk("midrst_no_rsp", 64'(rsp_valid), 64'd0);
        end
        rsp_ready = 1'b0;
        mv.valid = 4'hF;
        mv.data  = {12'($urandom), $urandom};
        mv.stall = 1;
        mv.expId = 0;
        applyStimulus(mv);
        checkOutput(mv);
        req_valid = '0;

        chk("scoreboard_empty", 64'(sbq.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
